// File: rtl/wcdma_ovsf_pkg.sv
// Shared types and constants for the WCDMA OVSF channel scheduler.
// Holds the FSM state encoding and the spreading-factor helper.
package wcdma_ovsf_pkg;

    localparam int SF_LOG2_MAX = 6;
    localparam int CODE_W      = 8;
    localparam int SF_LOG2_W   = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CFG  = 2'd1,
        ST_RUN  = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    // Returns SF-1 for SF = 2^(k+2); doubles as the legal-code mask.
    function automatic logic [CODE_W-1:0] sf_mask(input logic [SF_LOG2_W-1:0] k);
        return {CODE_W{1'b1}} >> (SF_LOG2_W'(SF_LOG2_MAX) - k);
    endfunction

endpackage

// File: rtl/wcdma_rr_arbiter.sv
// Combinational round-robin arbiter: lowest requester at or above ptr wins,
// otherwise wraps to the lowest requester overall. Grant is one-hot.
module wcdma_rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0] req,
    input  logic [2:0]      ptr,
    output logic [NREQ-1:0] grant
);

    logic [NREQ-1:0] mask;
    logic [NREQ-1:0] req_hi;
    logic [NREQ-1:0] sel;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_mask
            assign mask[gi] = (3'(gi) >= ptr);
        end
    endgenerate

    assign req_hi = req & mask;
    assign sel    = (|req_hi) ? req_hi : req;
    // Isolate lowest set bit.
    assign grant  = sel & (~sel + NREQ'(1));

endmodule

// File: rtl/wcdma_ovsf_sched.sv
// Schedules per-requester OVSF spreading bursts onto one code generator.
// Optional macro WCDMA_OVSF_SCHED_CHECK_EN adds the request legality check and ERR state.
module wcdma_ovsf_sched
    import wcdma_ovsf_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int SYM_W = 8
) (
    input  logic                   aclk,
    input  logic                   arst,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [3*NREQ-1:0]      req_sf_log2,
    input  logic [8*NREQ-1:0]      req_code,
    input  logic [SYM_W*NREQ-1:0]  req_nsym,
    input  logic                   abort,
    output logic                   gen_cfg_valid,
    input  logic                   gen_cfg_ready,
    output logic [SF_LOG2_W-1:0]   gen_cfg_sf_log2,
    output logic [CODE_W-1:0]      gen_cfg_code,
    output logic                   gen_chip_valid,
    input  logic                   gen_chip_ready,
    output logic                   gen_sym_last,
    output logic                   gen_burst_last,
    output logic [2:0]             grant_id,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    state_t               state_reg;
    logic [2:0]           ptr_reg;
    logic [2:0]           grant_id_reg;
    logic [SF_LOG2_W-1:0] sf_log2_reg;
    logic [CODE_W-1:0]    code_reg;
    logic [SYM_W-1:0]     nsym_reg;
    logic [CODE_W-1:0]    chip_reg;
    logic [SYM_W-1:0]     sym_reg;
    logic                 done_reg;

    logic [NREQ-1:0]      grant;
    logic [2:0]           win_id;
    logic [SF_LOG2_W-1:0] win_k;
    logic [CODE_W-1:0]    win_code;
    logic [SYM_W-1:0]     win_nsym;
    logic [SF_LOG2_W-1:0] lat_k;
    logic [CODE_W-1:0]    lat_code;
    logic                 chip_last;
    logic                 sym_last;
    logic                 chip_xfer;

    wcdma_rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req   (req_valid),
        .ptr   (ptr_reg),
        .grant (grant)
    );

    always_comb begin
        win_id   = '0;
        win_k    = '0;
        win_code = '0;
        win_nsym = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                win_id   = 3'(i);
                win_k    = req_sf_log2[i*SF_LOG2_W +: SF_LOG2_W];
                win_code = req_code[i*CODE_W +: CODE_W];
                win_nsym = req_nsym[i*SYM_W +: SYM_W];
            end
        end
    end

`ifdef WCDMA_OVSF_SCHED_CHECK_EN
    logic win_legal;
    assign win_legal = (win_k <= SF_LOG2_W'(SF_LOG2_MAX)) &&
                       ((win_code & ~sf_mask(win_k)) == '0);
    assign lat_k     = win_k;
    assign lat_code  = win_code;
    assign err       = (state_reg == ST_ERR);
`else
    // Without the check, out-of-range requests are coerced into a legal code.
    assign lat_k     = (win_k > SF_LOG2_W'(SF_LOG2_MAX)) ? SF_LOG2_W'(SF_LOG2_MAX) : win_k;
    assign lat_code  = win_code & sf_mask(lat_k);
    assign err       = 1'b0;
`endif

    assign chip_last       = (chip_reg == sf_mask(sf_log2_reg));
    assign sym_last        = (sym_reg == nsym_reg);
    assign busy            = (state_reg != ST_IDLE);
    // Gated by reset so a request held during reset is not acknowledged.
    assign req_ready       = (arst && state_reg == ST_IDLE) ? grant : '0;
    assign gen_cfg_valid   = (state_reg == ST_CFG);
    assign gen_cfg_sf_log2 = sf_log2_reg;
    assign gen_cfg_code    = code_reg;
    assign gen_chip_valid  = (state_reg == ST_RUN);
    assign gen_sym_last    = gen_chip_valid && chip_last;
    assign gen_burst_last  = gen_sym_last && sym_last;
    assign chip_xfer       = gen_chip_valid && gen_chip_ready;
    assign grant_id        = grant_id_reg;
    assign done            = done_reg;

    always_ff @(posedge aclk or negedge arst) begin
        if (!arst) begin
            state_reg    <= ST_IDLE;
            ptr_reg      <= '0;
            grant_id_reg <= '0;
            sf_log2_reg  <= '0;
            code_reg     <= '0;
            nsym_reg     <= '0;
            chip_reg     <= '0;
            sym_reg      <= '0;
            done_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (|grant) begin
                        ptr_reg      <= (win_id == 3'(NREQ-1)) ? 3'd0 : win_id + 3'd1;
                        grant_id_reg <= win_id;
                        sf_log2_reg  <= lat_k;
                        code_reg     <= lat_code;
                        nsym_reg     <= win_nsym;
`ifdef WCDMA_OVSF_SCHED_CHECK_EN
                        state_reg    <= win_legal ? ST_CFG : ST_ERR;
`else
                        state_reg    <= ST_CFG;
`endif
                    end
                end
                ST_CFG: begin
                    if (abort) begin
                        state_reg <= ST_IDLE;
                    end else if (gen_cfg_ready) begin
                        state_reg <= ST_RUN;
                        chip_reg  <= '0;
                        sym_reg   <= '0;
                    end
                end
                ST_RUN: begin
                    // Abort takes priority over a coincident final transfer.
                    if (abort) begin
                        state_reg <= ST_IDLE;
                    end else if (chip_xfer) begin
                        if (chip_last) begin
                            chip_reg <= '0;
                            if (sym_last) begin
                                state_reg <= ST_IDLE;
                                done_reg  <= 1'b1;
                            end else begin
                                sym_reg <= sym_reg + SYM_W'(1);
                            end
                        end else begin
                            chip_reg <= chip_reg + CODE_W'(1);
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/wcdma_ovsf_sched.md
WCDMA_OVSF_SCHED -- requirements
Module: wcdma_ovsf_sched

Interface
REQ-001 Parameter NREQ, default 4: number of channel requesters (2..8).
REQ-002 Parameter SYM_W, default 8: width of per-request symbol count.
REQ-003 aclk  in  1  sole clock; all logic rising-edge.
REQ-004 arst  in  1  reset, asynchronous assert, active-low (0 = reset).
REQ-005 req_valid  in  NREQ  per-requester request pending.
REQ-006 req_ready  out  NREQ  one-hot pulse: request of that requester latched this cycle.
REQ-007 req_sf_log2  in  3*NREQ  spreading factor code k; SF = 2^(k+2), legal k 0..6 (SF 4..256).
REQ-008 req_code  in  8*NREQ  OVSF code index; legal 0..SF-1.
REQ-009 req_nsym  in  SYM_W*NREQ  symbols to spread, minus one.
REQ-010 abort  in  1  terminate current burst.
REQ-011 gen_cfg_valid / gen_cfg_ready  out / in  1 / 1  configuration handshake to OVSF generator.
REQ-012 gen_cfg_sf_log2 / gen_cfg_code  out  3 / 8  configuration payload, stable while gen_cfg_valid=1.
REQ-013 gen_chip_valid / gen_chip_ready  out / in  1 / 1  chip-strobe handshake; transfer = both high.
REQ-014 gen_sym_last / gen_burst_last  out  1 / 1  qualify transfer: last chip of symbol / of burst.
REQ-015 grant_id  out  3  index of latched requester; busy  out  1  state != IDLE.
REQ-016 done  out  1  one-cycle pulse after burst completes; err  out  1  one-cycle pulse on rejected request.

Function
REQ-017 FSM states IDLE, CFG, RUN, ERR; encoding from shared package.
REQ-018 IDLE: if any req_valid, round-robin grant starting from pointer; winner's req_ready=1 same cycle; payload and winner id latched.
REQ-019 Round-robin pointer SHALL move to winner+1 (mod NREQ) on each grant, including rejected ones.
REQ-020 Grant cycle: k>6 or code >= 2^(k+2) -> ERR next cycle; else CFG next cycle.
REQ-021 ERR: err=1 for exactly one cycle, then IDLE; no generator handshake occurs.
REQ-022 CFG: gen_cfg_valid=1 until gen_cfg_ready sampled high; then RUN with chip and symbol counters cleared.
REQ-023 RUN: gen_chip_valid=1 every cycle; counters advance only on transfer; gen_chip_valid low in all other states.
REQ-024 Chip counter wraps at SF-1 with gen_sym_last=1; symbol counter increments on wrap.
REQ-025 Transfer with chip=SF-1 and symbol=nsym: gen_burst_last=1; next cycle IDLE with done=1.
REQ-026 Minimum latency: grant at t, gen_cfg_valid at t+1, first chip transfer at t+2 if both readies held high.
REQ-027 abort=1 in CFG or RUN -> IDLE next cycle, no done; abort wins over a simultaneous final transfer; abort ignored in IDLE/ERR.
REQ-028 req_valid changes while busy SHALL not affect latched payload.

Reset
REQ-029 Reset values: state IDLE, pointer 0, counters 0, grant_id 0, all outputs 0.
REQ-030 Reset mid-burst SHALL abandon burst immediately; no done or err after release.

Configuration
REQ-031 Macro WCDMA_OVSF_SCHED_CHECK_EN defined: REQ-020 legality check and ERR state present.
REQ-032 Macro undefined: no ERR state, err tied 0; k clipped to 6 and code masked to low k+2 bits, then CFG.

Structure
REQ-033 Package wcdma_ovsf_pkg SHALL hold state enum, SF_LOG2_MAX=6, CODE_W=8, SF_LOG2_W=3.
REQ-034 Round-robin grant logic SHALL be sub-module wcdma_rr_arbiter (NREQ parameter, req/pointer in, one-hot grant out).

Verification
REQ-035 Req 1: k=0, code=3, nsym=1, readies high -> cfg at t+1, 8 transfers, sym_last on 4th and 8th, burst_last on 8th, done at next cycle.
REQ-036 All 4 requesters valid continuously -> grant order 0,1,2,3,0; req_ready one-hot each grant.
REQ-037 k=2, code=16 with CHECK_EN -> err one cycle, no gen_cfg_valid; without macro -> code 0 configured.
REQ-038 gen_chip_ready toggled 50% during k=6, nsym=0 -> exactly 256 transfers, counters hold when stalled.
REQ-039 abort asserted on final transfer cycle -> IDLE next cycle, done stays 0.
REQ-040 arst low during RUN -> all outputs 0 asynchronously; after release, pending request granted from requester 0.
